// File: rtl/trace_pkg.sv
// Shared types and constants for the CPU trace emitter.
// Build option: TRACE_PAD_EN adds the cosmetic spaces after ':', after the
// register digit and after '='. When it is undefined those spaces are skipped.
package trace_pkg;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_CONV,
    ST_CARET,
    ST_TIME,
    ST_AT,
    ST_PC,
    ST_COLON,
    ST_SP_A,
    ST_DOLLAR,
    ST_STAR,
    ST_REG,
    ST_SP_B,
    ST_ADDR,
    ST_LT,
    ST_EQ,
    ST_SP_C,
    ST_DATA,
    ST_HASH
  } state_t;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_LT     = 8'h3C;
  localparam logic [7:0] CH_EQ     = 8'h3D;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_ZERO   = 8'h30;

`ifdef TRACE_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  // Nibble to lowercase ASCII hex digit ('a' = 0x57 + 10).
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) begin
      hex_char = CH_ZERO + {4'h0, nib};
    end else begin
      hex_char = 8'h57 + {4'h0, nib};
    end
  endfunction

endpackage

// File: rtl/trace_bin2bcd.sv
// Iterative double-dabble converter: W-bit binary to four BCD digits.
// done pulses exactly W cycles after start is sampled; bcd then holds until
// the next start.
module trace_bin2bcd #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic [15:0]  bcd,
  output logic         done
);
  import trace_pkg::*;

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  bin_reg;
  logic [15:0]   bcd_reg;
  logic [15:0]   bcd_adj;
  logic [CW-1:0] cnt_reg;
  logic          busy_reg;
  logic          done_reg;

  // Add-3 correction on every digit that is 5 or more, ahead of each shift.
  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                (bcd_reg[gi*4 +: 4] + 4'd3) : bcd_reg[gi*4 +: 4];
  end

  // Load on start, then one correct-and-shift step per cycle for W cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_reg  <= '0;
      bcd_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        bin_reg  <= bin;
        bcd_reg  <= '0;
        cnt_reg  <= CW'(W);
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
        cnt_reg <= cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign bcd  = bcd_reg;
  assign done = done_reg;

endmodule

// File: rtl/cpu_trace_emitter.sv
// Serializes one CPU write-back event into an ASCII trace line, one character
// per accepted out beat. Build option: TRACE_PAD_EN (see trace_pkg).
module cpu_trace_emitter #(
  parameter int TIME_W   = 14,
  parameter int TIME_MAX = 9999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_mem,
  input  logic [TIME_W-1:0] req_time,
  input  logic [31:0]       req_pc,
  input  logic [3:0]        req_reg,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_data,
  output logic [7:0]        out_char,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_pulse
);
  import trace_pkg::*;

  state_t      state_reg, state_next;
  logic [1:0]  digit_reg, digit_next;
  logic [2:0]  nib_reg, nib_next;
  logic        mem_reg;
  logic [31:0] pc_reg, addr_reg, data_reg;
  logic [3:0]  reg_reg;
  logic        err_reg;
  logic        start, illegal;

  logic [TIME_W-1:0] time_sat;
  logic [15:0]       bcd_val;
  logic              conv_done;
  logic [31:0]       hex_field, hex_shift;
  logic [15:0]       dig_shift;

  assign time_sat = (req_time > TIME_W'(TIME_MAX)) ? TIME_W'(TIME_MAX) : req_time;

  trace_bin2bcd #(.W(TIME_W)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (time_sat),
    .bcd   (bcd_val),
    .done  (conv_done)
  );

  // Index of the most significant non-zero decimal digit (0 when value is 0).
  function automatic logic [1:0] lead_digit(input logic [15:0] b);
    if (b[15:12] != 4'd0)     lead_digit = 2'd3;
    else if (b[11:8] != 4'd0) lead_digit = 2'd2;
    else if (b[7:4] != 4'd0)  lead_digit = 2'd1;
    else                      lead_digit = 2'd0;
  endfunction

  // nib_reg = 0 addresses the most significant nibble.
  assign hex_field = (state_reg == ST_PC)   ? pc_reg :
                     (state_reg == ST_ADDR) ? addr_reg : data_reg;
  assign hex_shift = hex_field >> {~nib_reg, 2'b00};
  assign dig_shift = bcd_val >> {digit_reg, 2'b00};

  // Next-state, counters and the character presented in each state.
  always_comb begin
    state_next = state_reg;
    digit_next = digit_reg;
    nib_next   = nib_reg;
    out_valid  = 1'b0;
    out_char   = 8'h00;
    req_ready  = 1'b0;
    start      = 1'b0;
    illegal    = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!req_mem && (req_reg > 4'd9)) begin
            illegal = 1'b1;
          end else begin
            start      = 1'b1;
            state_next = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        if (conv_done) state_next = ST_CARET;
      end
      ST_CARET: begin
        out_valid = 1'b1;
        out_char  = CH_CARET;
        if (out_ready) begin
          state_next = ST_TIME;
          digit_next = lead_digit(bcd_val);
        end
      end
      ST_TIME: begin
        out_valid = 1'b1;
        out_char  = CH_ZERO + {4'h0, dig_shift[3:0]};
        if (out_ready) begin
          if (digit_reg == 2'd0) state_next = ST_AT;
          else                   digit_next = digit_reg - 2'd1;
        end
      end
      ST_AT: begin
        out_valid = 1'b1;
        out_char  = CH_AT;
        if (out_ready) state_next = ST_PC;
      end
      ST_PC, ST_ADDR, ST_DATA: begin
        out_valid = 1'b1;
        out_char  = hex_char(hex_shift[3:0]);
        if (out_ready) begin
          nib_next = nib_reg + 3'd1;
          if (nib_reg == 3'd7) begin
            if (state_reg == ST_PC)        state_next = ST_COLON;
            else if (state_reg == ST_ADDR) state_next = ST_LT;
            else                           state_next = ST_HASH;
          end
        end
      end
      ST_COLON: begin
        out_valid = 1'b1;
        out_char  = CH_COLON;
        if (out_ready) state_next = PAD_EN ? ST_SP_A : (mem_reg ? ST_STAR : ST_DOLLAR);
      end
      ST_SP_A: begin
        out_valid = 1'b1;
        out_char  = CH_SP;
        if (out_ready) state_next = mem_reg ? ST_STAR : ST_DOLLAR;
      end
      ST_DOLLAR: begin
        out_valid = 1'b1;
        out_char  = CH_DOLLAR;
        if (out_ready) state_next = ST_REG;
      end
      ST_STAR: begin
        out_valid = 1'b1;
        out_char  = CH_STAR;
        if (out_ready) state_next = ST_ADDR;
      end
      ST_REG: begin
        out_valid = 1'b1;
        out_char  = CH_ZERO + {4'h0, reg_reg};
        if (out_ready) state_next = PAD_EN ? ST_SP_B : ST_LT;
      end
      ST_SP_B: begin
        out_valid = 1'b1;
        out_char  = CH_SP;
        if (out_ready) state_next = ST_LT;
      end
      ST_LT: begin
        out_valid = 1'b1;
        out_char  = CH_LT;
        if (out_ready) state_next = ST_EQ;
      end
      ST_EQ: begin
        out_valid = 1'b1;
        out_char  = CH_EQ;
        if (out_ready) state_next = PAD_EN ? ST_SP_C : ST_DATA;
      end
      ST_SP_C: begin
        out_valid = 1'b1;
        out_char  = CH_SP;
        if (out_ready) state_next = ST_DATA;
      end
      ST_HASH: begin
        out_valid = 1'b1;
        out_char  = CH_HASH;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, counters, captured request fields and the error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      digit_reg <= 2'd0;
      nib_reg   <= 3'd0;
      mem_reg   <= 1'b0;
      pc_reg    <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      reg_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      digit_reg <= digit_next;
      nib_reg   <= nib_next;
      err_reg   <= illegal;
      if (start) begin
        mem_reg  <= req_mem;
        pc_reg   <= req_pc;
        addr_reg <= req_addr;
        data_reg <= req_data;
        reg_reg  <= req_reg;
      end
    end
  end

  assign err_pulse = err_reg;

endmodule
